// File: rtl/fetch_controller_if.sv
// ---------------------------------------------------------------------------
// fetch_controller_if
//   Request/response bus between the fetch controller and the instruction
//   cache. One access is outstanding at a time: the requester raises
//   icache_req_out with a stable icache_addr_out and holds it until the cache
//   answers with a single-cycle icache_done_in pulse carrying icache_data_in.
//
//   Signals
//     icache_req_out   requester -> cache   access request, held until done
//     icache_addr_out  requester -> cache   fetch address, stable while req=1
//     icache_done_in   cache -> requester   1-cycle completion pulse
//     icache_data_in   cache -> requester   instruction word, valid with done
//
//   Modports
//     master  the fetch controller (drives req/addr)
//     slave   the instruction cache (drives done/data)
// ---------------------------------------------------------------------------
interface fetch_controller_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  icache_req_out;
    logic [WORD_WIDTH-1:0] icache_addr_out;
    logic                  icache_done_in;
    logic [WORD_WIDTH-1:0] icache_data_in;

    modport master (
        output icache_req_out,
        output icache_addr_out,
        input  icache_done_in,
        input  icache_data_in
    );

    modport slave (
        input  icache_req_out,
        input  icache_addr_out,
        output icache_done_in,
        output icache_data_in
    );
endinterface

// File: rtl/fetch_controller.sv
// ---------------------------------------------------------------------------
// fetch_controller
//   Fetch-stage sequencer. Owns the PC, issues one I-cache request at a time
//   and hands each returned instruction plus its PC to the fetch pipeline
//   registers with a one-cycle valid pulse. Handles decode back-pressure
//   (stall_in) and PC redirects, including redirects that arrive while an
//   access is already in flight. Redirect always wins over stall.
//
//   Ports
//     clk               clock, all state updates on posedge
//     reset             synchronous active-high reset
//     stall_in          decode cannot accept an instruction
//     redirect_in       load redirect_pc_in as the next fetch PC
//     redirect_pc_in    redirect target, bits [1:0] forced to zero
//     icache            I-cache request/response bus (master side)
//     valid_out         1-cycle pulse: instr_out/pc_out carry a new entry
//     instr_out         delivered instruction (registered)
//     pc_out            PC of the delivered instruction (registered)
//     stall_cycles_out  saturating count of cycles spent in HOLD
// ---------------------------------------------------------------------------
module fetch_controller #(
    parameter int                       WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0]    PC_RESET   = 'h1000,
    parameter int                       CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall_in,
    input  logic                  redirect_in,
    input  logic [WORD_WIDTH-1:0] redirect_pc_in,
    fetch_controller_if.master    icache,
    output logic                  valid_out,
    output logic [WORD_WIDTH-1:0] instr_out,
    output logic [WORD_WIDTH-1:0] pc_out,
    output logic [CNT_WIDTH-1:0]  stall_cycles_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t                state;
    state_t                next_state;
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] pending_tgt;
    logic [WORD_WIDTH-1:0] hold_buf;
    logic [WORD_WIDTH-1:0] redirect_target;
    logic [WORD_WIDTH-1:0] pc_next_seq;

    // Instructions are word aligned, so the low two target bits are dropped.
    assign redirect_target = {redirect_pc_in[WORD_WIDTH-1:2], 2'b00};
    assign pc_next_seq     = pc + WORD_WIDTH'(4);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A redirect seen without done cannot cancel the access
    // already issued to the cache, so it parks in DISCARD until that access
    // completes and its data can be thrown away.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: next_state = FETCH;
            FETCH: begin
                if (icache.icache_done_in) begin
                    if (redirect_in) begin
                        next_state = FETCH;
                    end else if (stall_in) begin
                        next_state = HOLD;
                    end else begin
                        next_state = FETCH;
                    end
                end else if (redirect_in) begin
                    next_state = DISCARD;
                end
            end
            DISCARD: begin
                if (icache.icache_done_in) begin
                    next_state = FETCH;
                end
            end
            HOLD: begin
                if (redirect_in || !stall_in) begin
                    next_state = FETCH;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output logic. The request stays up through DISCARD because the cache
    // still owes us the completion of the old address; pc is not updated
    // until then, so the address remains stable.
    always_comb begin
        icache.icache_req_out  = 1'b0;
        icache.icache_addr_out = '0;
        if (state == FETCH || state == DISCARD) begin
            icache.icache_req_out  = 1'b1;
            icache.icache_addr_out = pc;
        end
    end

    // Datapath: PC, pending redirect target, the word buffered across a
    // stall, the delivered instruction registers and the stall counter.
    // valid_out defaults low so it can only ever be a single-cycle pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= PC_RESET;
            pending_tgt      <= '0;
            hold_buf         <= '0;
            valid_out        <= 1'b0;
            instr_out        <= '0;
            pc_out           <= '0;
            stall_cycles_out <= '0;
        end else begin
            valid_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    // Nothing is in flight yet, so a redirect here applies directly.
                    if (redirect_in) begin
                        pc <= redirect_target;
                    end
                end
                FETCH: begin
                    if (icache.icache_done_in) begin
                        if (redirect_in) begin
                            pc <= redirect_target;
                        end else if (stall_in) begin
                            hold_buf <= icache.icache_data_in;
                        end else begin
                            instr_out <= icache.icache_data_in;
                            pc_out    <= pc;
                            valid_out <= 1'b1;
                            pc        <= pc_next_seq;
                        end
                    end else if (redirect_in) begin
                        pending_tgt <= redirect_target;
                    end
                end
                DISCARD: begin
                    // The most recent redirect wins, even one arriving with done.
                    if (redirect_in) begin
                        pending_tgt <= redirect_target;
                    end
                    if (icache.icache_done_in) begin
                        pc <= redirect_in ? redirect_target : pending_tgt;
                    end
                end
                HOLD: begin
                    if (!(&stall_cycles_out)) begin
                        stall_cycles_out <= stall_cycles_out + CNT_WIDTH'(1);
                    end
                    if (redirect_in) begin
                        pc <= redirect_target;
                    end else if (!stall_in) begin
                        instr_out <= hold_buf;
                        pc_out    <= pc;
                        valid_out <= 1'b1;
                        pc        <= pc_next_seq;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// ---------------------------------------------------------------------------
// tb_fetch_controller
//   Directed testbench for fetch_controller. Every delivery the stimulus
//   expects is pushed to a scoreboard queue as it is driven; a monitor pops
//   and compares on each valid_out pulse. Inputs change 1 time unit after the
//   rising edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_fetch_controller;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } expect_t;

    logic        clk;
    logic        reset;
    logic        stall_in;
    logic        redirect_in;
    logic [31:0] redirect_pc_in;
    logic        valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [15:0] stall_cycles_out;

    int      vectors;
    int      miscompares;
    expect_t sb_q[$];

    fetch_controller_if #(.WORD_WIDTH(32)) icache_bus ();

    fetch_controller #(
        .WORD_WIDTH (32),
        .PC_RESET   (32'h1000),
        .CNT_WIDTH  (16)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall_in         (stall_in),
        .redirect_in      (redirect_in),
        .redirect_pc_in   (redirect_pc_in),
        .icache           (icache_bus),
        .valid_out        (valid_out),
        .instr_out        (instr_out),
        .pc_out           (pc_out),
        .stall_cycles_out (stall_cycles_out)
    );

    // 10-unit clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and report and count it on mismatch.
    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rst, input logic stall, input logic redir,
                                  input logic [31:0] rpc, input logic done,
                                  input logic [31:0] data);
        reset                     = rst;
        stall_in                  = stall;
        redirect_in               = redir;
        redirect_pc_in            = rpc;
        icache_bus.icache_done_in = done;
        icache_bus.icache_data_in = data;
    endtask

    task automatic expect_delivery(input logic [31:0] instr, input logic [31:0] pc);
        expect_t e;
        e.instr = instr;
        e.pc    = pc;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every valid_out pulse must match the oldest entry.
    always @(negedge clk) begin
        if (valid_out === 1'b1) begin
            check_output("valid_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                expect_t e;
                e = sb_q.pop_front();
                check_output("deliver_instr", instr_out, e.instr);
                check_output("deliver_pc", pc_out, e.pc);
            end
        end
    end

    initial begin
        vectors     = 0;
        miscompares = 0;

        // Reset state
        apply_stimulus(1, 0, 0, 0, 0, 0);
        tick();
        tick();
        @(negedge clk);
        check_output("rst_req", 32'(icache_bus.icache_req_out), 32'd0);
        check_output("rst_addr", icache_bus.icache_addr_out, 32'h0);
        check_output("rst_valid", 32'(valid_out), 32'd0);
        check_output("rst_instr", instr_out, 32'h0);
        check_output("rst_pc_out", pc_out, 32'h0);
        check_output("rst_cnt", 32'(stall_cycles_out), 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("idle_req", 32'(icache_bus.icache_req_out), 32'd0);
        tick();

        // 1) Sequential fetch, done every second cycle
        apply_stimulus(0, 0, 0, 0, 1, 32'hA);
        expect_delivery(32'hA, 32'h1000);
        @(negedge clk);
        check_output("t1_req", 32'(icache_bus.icache_req_out), 32'd1);
        check_output("t1_addr0", icache_bus.icache_addr_out, 32'h1000);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("t1_addr1", icache_bus.icache_addr_out, 32'h1004);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 32'hA);
        expect_delivery(32'hA, 32'h1004);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("t1_addr2", icache_bus.icache_addr_out, 32'h1008);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 32'h1234_5678);
        expect_delivery(32'h1234_5678, 32'h1008);
        tick();

        // 2) Stall around done -> HOLD for three cycles
        apply_stimulus(0, 1, 0, 0, 1, 32'hB0B0_B0B0);
        @(negedge clk);
        check_output("t2_addr", icache_bus.icache_addr_out, 32'h100C);
        tick();
        apply_stimulus(0, 1, 0, 0, 0, 0);
        @(negedge clk);
        check_output("t2_hold_req", 32'(icache_bus.icache_req_out), 32'd0);
        tick();
        apply_stimulus(0, 1, 0, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        expect_delivery(32'hB0B0_B0B0, 32'h100C);
        @(negedge clk);
        check_output("t2_hold_req2", 32'(icache_bus.icache_req_out), 32'd0);
        tick();
        @(negedge clk);
        check_output("t2_cnt", 32'(stall_cycles_out), 32'd3);
        check_output("t2_next_addr", icache_bus.icache_addr_out, 32'h1010);
        tick();

        // 3) Redirect before done -> DISCARD; last redirect wins
        apply_stimulus(0, 0, 1, 32'h4444, 0, 0);
        @(negedge clk);
        check_output("t3_addr_pre", icache_bus.icache_addr_out, 32'h1010);
        tick();
        apply_stimulus(0, 0, 1, 32'h2003, 0, 0);
        @(negedge clk);
        check_output("t3_discard_req", 32'(icache_bus.icache_req_out), 32'd1);
        check_output("t3_discard_addr", icache_bus.icache_addr_out, 32'h1010);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("t3_new_addr", icache_bus.icache_addr_out, 32'h2000);
        tick();

        // 4) done + redirect + stall together -> FETCH at target, no delivery
        apply_stimulus(0, 1, 1, 32'h3005, 1, 32'h0BAD_0BAD);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("t4_req", 32'(icache_bus.icache_req_out), 32'd1);
        check_output("t4_addr", icache_bus.icache_addr_out, 32'h3004);
        check_output("t4_cnt", 32'(stall_cycles_out), 32'd3);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 32'hC0DE);
        expect_delivery(32'hC0DE, 32'h3004);
        tick();

        // 5) Reset while a request is outstanding; late done ignored
        apply_stimulus(1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("t5_req_pre", 32'(icache_bus.icache_req_out), 32'd1);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 32'hEEEE_EEEE);
        @(negedge clk);
        check_output("t5_req", 32'(icache_bus.icache_req_out), 32'd0);
        check_output("t5_addr", icache_bus.icache_addr_out, 32'h0);
        check_output("t5_valid", 32'(valid_out), 32'd0);
        check_output("t5_instr", instr_out, 32'h0);
        check_output("t5_pc_out", pc_out, 32'h0);
        check_output("t5_cnt", 32'(stall_cycles_out), 32'd0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("t5_restart_req", 32'(icache_bus.icache_req_out), 32'd1);
        check_output("t5_restart_addr", icache_bus.icache_addr_out, 32'h1000);
        tick();

        // 6) PC wrap and counter saturation
        apply_stimulus(0, 0, 1, 32'hFFFF_FFFF, 1, 32'h1111_1111);
        tick();
        apply_stimulus(0, 0, 0, 0, 1, 32'h600D);
        expect_delivery(32'h600D, 32'hFFFF_FFFC);
        @(negedge clk);
        check_output("t6_addr_top", icache_bus.icache_addr_out, 32'hFFFF_FFFC);
        tick();
        apply_stimulus(0, 1, 0, 0, 1, 32'h5A5A_5A5A);
        @(negedge clk);
        check_output("t6_addr_wrap", icache_bus.icache_addr_out, 32'h0);
        tick();
        apply_stimulus(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        @(negedge clk);
        check_output("t6_cnt_fffe", 32'(stall_cycles_out), 32'h0000_FFFE);
        check_output("t6_hold_req", 32'(icache_bus.icache_req_out), 32'd0);
        tick();
        @(negedge clk);
        check_output("t6_cnt_ffff", 32'(stall_cycles_out), 32'h0000_FFFF);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        @(negedge clk);
        check_output("t6_cnt_sat", 32'(stall_cycles_out), 32'h0000_FFFF);
        apply_stimulus(0, 0, 0, 0, 0, 0);
        expect_delivery(32'h5A5A_5A5A, 32'h0);
        tick();
        @(negedge clk);
        check_output("t6_cnt_after", 32'(stall_cycles_out), 32'h0000_FFFF);
        check_output("t6_addr_after", icache_bus.icache_addr_out, 32'h4);
        tick();
        tick();

        check_output("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
